prefetch_line_buffer: RTL and testbench
=======================================

Name: prefetch_line_buffer

Overview:
- Sits directly downstream of the next-line prefetcher in the fetch stage.
- Accepts its prefetch requests and issues line reads to the memory arbiter.
- Holds returned lines in a small fully-associative buffer.
- The I-cache probes the buffer on a miss; a hit supplies the line without a memory round trip and consumes the entry.

Parameters:
- XLEN, 32, address width.
- BLK_SIZE, 128, cache line width in bits; LINE_BYTES = BLK_SIZE/8, OFFSET_BITS = log2(LINE_BYTES).
- NUM_ENTRIES, 2, number of buffered lines; power of two, >= 1.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  pipeline flush; invalidates the buffer and cancels the prefetch.
- pf_valid_i  in  1  prefetch request valid from the prefetcher.
- pf_addr_i  in  XLEN  prefetch address, line-aligned.
- pf_ack_o  out  1  request accepted this cycle.
- mem_req_o  out  1  memory line-read request.
- mem_addr_o  out  XLEN  line-aligned read address.
- mem_gnt_i  in  1  arbiter grant for mem_req_o.
- mem_rvalid_i  in  1  read data valid (one beat = full line).
- mem_rdata_i  in  BLK_SIZE  returned line.
- lookup_valid_i  in  1  I-cache miss probe valid.
- lookup_addr_i  in  XLEN  probe address (any byte offset).
- lookup_hit_o  out  1  probe hits a valid entry.
- lookup_data_o  out  BLK_SIZE  line of the hitting entry; '0 on miss.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; all entry valid bits, wr_ptr and request address cleared.
  - All outputs 0.
- Tag compare uses bits [XLEN-1:OFFSET_BITS] only.
- FSM states: IDLE, REQ, WAIT_RESP, DRAIN.
- IDLE:
  - pf_ack_o = pf_valid_i && !flush_i (combinational).
  - On ack with pf_addr_i tag matching a valid entry: drop the request, stay IDLE.
  - Otherwise: capture the line-aligned address, go to REQ.
- REQ:
  - mem_req_o=1 and mem_addr_o=captured address, both stable until grant.
  - mem_gnt_i -> WAIT_RESP.
  - flush_i before grant -> IDLE; the request is withdrawn (the arbiter permits withdrawal before grant).
  - If flush_i and mem_gnt_i arrive in the same cycle, the grant stands -> DRAIN.
- WAIT_RESP:
  - mem_rvalid_i: write the line and tag into slot wr_ptr, set valid, wr_ptr = (wr_ptr+1) mod NUM_ENTRIES -> IDLE.
  - flush_i -> DRAIN. If flush_i and mem_rvalid_i are in the same cycle, the data is discarded -> IDLE.
- DRAIN:
  - mem_rvalid_i: discard the data -> IDLE. No outstanding read is ever abandoned.
- Replacement: FIFO by wr_ptr. A full buffer overwrites the oldest slot regardless of its valid bit.
- Lookup:
  - Purely combinational against valid entries. Tags are unique by construction (duplicate filter), so at most one entry hits.
  - lookup_hit_o = lookup_valid_i && match.
  - A hit with lookup_valid_i clears that entry's valid bit at the next edge.
- Simultaneous events:
  - A fill and a lookup of the same line in the same cycle: lookup misses; there is no bypass of mem_rdata_i.
  - A fill into a slot being consumed by a hit in the same cycle: the fill wins and the slot ends valid with the new line.
  - flush_i clears all valid bits at the next edge and overrides any same-cycle fill.
  - A lookup in the flush cycle still sees the pre-flush contents.
- pf_ack_o is never asserted outside IDLE; the prefetcher holds its request meanwhile.
- Latency:
  - Prefetch ack to mem_req_o: 1 cycle.
  - rvalid to a hit being available: 1 cycle.
- mem_addr_o[OFFSET_BITS-1:0] is always 0.

Test Plan:
- pf_addr_i=0x1010, immediate gnt, rvalid one cycle later with data D1:
  - pf_ack_o pulses once; mem_addr_o=0x1010; busy_o high 2 cycles.
  - Next cycle lookup 0x101C -> lookup_hit_o=1, data=D1.
  - Second lookup of 0x1010 -> miss.
- Fill 0x2000, then request pf_addr_i=0x2000 again:
  - Acked and dropped; mem_req_o stays 0.
- With NUM_ENTRIES=2, fill 0x100, 0x110, 0x120:
  - Lookups: 0x100 miss; 0x110 and 0x120 hit.
- Grant for 0x300, then flush_i in WAIT_RESP, rvalid 3 cycles later:
  - busy_o stays high until rvalid; no entry written; lookup 0x300 misses.
  - No pf_ack_o until IDLE.
- flush_i in REQ before gnt:
  - mem_req_o drops the next cycle, state=IDLE, no fill.
- Assert rst_ni low mid-WAIT_RESP:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, an earlier-filled line misses on lookup.

Source files
------------

// File: rtl/prefetch_line_buffer.sv
// Fully-associative buffer for next-line prefetches. It issues one line read at a
// time and serves I-cache miss probes combinationally. A hit consumes the entry.
module prefetch_line_buffer_entry #(
    parameter int TAG_W    = 28,
    parameter int BLK_SIZE = 128
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                fill_i,
    input  logic                consume_i,
    input  logic [TAG_W-1:0]    fill_tag_i,
    input  logic [BLK_SIZE-1:0] fill_data_i,
    input  logic [TAG_W-1:0]    lk_tag_i,
    input  logic [TAG_W-1:0]    pf_tag_i,
    output logic                lk_match_o,
    output logic                pf_match_o,
    output logic [BLK_SIZE-1:0] data_o
);
    logic                valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q;
    logic [BLK_SIZE-1:0] data_q;

    // Priority: flush over fill over consume.
    always_comb begin
        valid_d = valid_q;
        if (consume_i) valid_d = 1'b0;
        if (fill_i)    valid_d = 1'b1;
        if (clr_i)     valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (fill_i) begin
                tag_q  <= fill_tag_i;
                data_q <= fill_data_i;
            end
        end
    end

    assign lk_match_o = valid_q && (tag_q == lk_tag_i);
    assign pf_match_o = valid_q && (tag_q == pf_tag_i);
    assign data_o     = data_q;
endmodule

module prefetch_line_buffer #(
    parameter int XLEN        = 32,
    parameter int BLK_SIZE    = 128,
    parameter int NUM_ENTRIES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                pf_valid_i,
    input  logic [XLEN-1:0]     pf_addr_i,
    output logic                pf_ack_o,
    output logic                mem_req_o,
    output logic [XLEN-1:0]     mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [BLK_SIZE-1:0] mem_rdata_i,
    input  logic                lookup_valid_i,
    input  logic [XLEN-1:0]     lookup_addr_i,
    output logic                lookup_hit_o,
    output logic [BLK_SIZE-1:0] lookup_data_o,
    output logic                busy_o
);
    localparam int OFFSET_BITS = $clog2(BLK_SIZE / 8);
    localparam int TAG_W       = XLEN - OFFSET_BITS;
    localparam int PTR_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DRAIN} state_e;

    state_e                                 state_q, state_d;
    logic [TAG_W-1:0]                       req_tag_q, req_tag_d;
    logic [PTR_W-1:0]                       wr_ptr_q, wr_ptr_d;
    logic [NUM_ENTRIES-1:0]                 lk_match, pf_match;
    logic [NUM_ENTRIES-1:0][BLK_SIZE-1:0]   ent_data;
    logic [TAG_W-1:0]                       lk_tag, pf_tag;
    logic                                   accept, pf_dup, fill_en;
    logic                                   unused_offsets;

    assign lk_tag  = lookup_addr_i[XLEN-1:OFFSET_BITS];
    assign pf_tag  = pf_addr_i[XLEN-1:OFFSET_BITS];
    assign unused_offsets = ^{pf_addr_i[OFFSET_BITS-1:0], lookup_addr_i[OFFSET_BITS-1:0]};
    assign accept  = (state_q == IDLE) && pf_valid_i && !flush_i;
    assign pf_dup  = |pf_match;
    // A fill that collides with a flush is discarded.
    assign fill_en = (state_q == WAIT_RESP) && mem_rvalid_i && !flush_i;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
        prefetch_line_buffer_entry #(.TAG_W(TAG_W), .BLK_SIZE(BLK_SIZE)) u_ent (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .clr_i       (flush_i),
            .fill_i      (fill_en && (wr_ptr_q == PTR_W'(i))),
            .consume_i   (lookup_valid_i && lk_match[i]),
            .fill_tag_i  (req_tag_q),
            .fill_data_i (mem_rdata_i),
            .lk_tag_i    (lk_tag),
            .pf_tag_i    (pf_tag),
            .lk_match_o  (lk_match[i]),
            .pf_match_o  (pf_match[i]),
            .data_o      (ent_data[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            req_tag_q <= '0;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_tag_q <= req_tag_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // A granted read is always drained, even across a flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept && !pf_dup) state_d = REQ;
            REQ:       if (mem_gnt_i)         state_d = flush_i ? DRAIN : WAIT_RESP;
                       else if (flush_i)      state_d = IDLE;
            WAIT_RESP: if (mem_rvalid_i)      state_d = IDLE;
                       else if (flush_i)      state_d = DRAIN;
            DRAIN:     if (mem_rvalid_i)      state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_comb begin
        pf_ack_o  = accept;
        mem_req_o = (state_q == REQ);
        busy_o    = (state_q != IDLE);
    end

    always_comb begin
        req_tag_d = (accept && !pf_dup) ? pf_tag : req_tag_q;
        wr_ptr_d  = wr_ptr_q;
        if (fill_en) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end

    assign mem_addr_o = {req_tag_q, {OFFSET_BITS{1'b0}}};

    always_comb begin
        lookup_hit_o  = 1'b0;
        lookup_data_o = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (lookup_valid_i && lk_match[i]) begin
                lookup_hit_o  = 1'b1;
                lookup_data_o = lookup_data_o | ent_data[i];
            end
        end
    end
endmodule

// File: tb/tb_prefetch_line_buffer.sv
// Directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a line-level model of the buffer.
module tb_prefetch_line_buffer;
    localparam int NE = 2;

    logic         clk = 0, rst_n = 0;
    logic         flush = 0, pf_valid = 0, gnt = 0, rvalid = 0, lk_valid = 0;
    logic [31:0]  pf_addr = 0, lk_addr = 0;
    logic [127:0] rdata = 0;
    logic         pf_ack, mem_req, lk_hit, busy;
    logic [31:0]  mem_addr;
    logic [127:0] lk_data;

    int checks = 0, errors = 0;

    prefetch_line_buffer #(.XLEN(32), .BLK_SIZE(128), .NUM_ENTRIES(NE)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .pf_valid_i(pf_valid), .pf_addr_i(pf_addr), .pf_ack_o(pf_ack),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(gnt),
        .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
        .lookup_valid_i(lk_valid), .lookup_addr_i(lk_addr),
        .lookup_hit_o(lk_hit), .lookup_data_o(lk_data), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- line-level model ----------------
    bit           m_v[NE];
    int unsigned  m_line[NE];
    logic [127:0] m_data[NE];
    int           m_ptr = 0;
    bit           m_req = 0;  // read being requested, not yet granted
    bit           m_out = 0;  // read granted, data still to come
    bit           m_keep = 0; // returned data should be kept
    logic [31:0]  m_addr = 0;

    function automatic int find(input logic [31:0] a);
        for (int i = 0; i < NE; i++)
            if (m_v[i] && m_line[i] == a[31:4]) return i;
        return -1;
    endfunction

    always @(negedge rst_n) begin
        for (int i = 0; i < NE; i++) m_v[i] = 0;
        m_ptr = 0; m_req = 0; m_out = 0; m_keep = 0; m_addr = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            int li, pi;
            li = find(lk_addr);
            pi = find(pf_addr);
            if (lk_valid && li >= 0) m_v[li] = 0;
            if (m_req) begin
                if (gnt) begin m_req = 0; m_out = 1; m_keep = !flush; end
                else if (flush) m_req = 0;
            end else if (m_out) begin
                if (rvalid) begin
                    m_out = 0;
                    if (m_keep && !flush) begin
                        m_v[m_ptr] = 1; m_line[m_ptr] = m_addr[31:4]; m_data[m_ptr] = rdata;
                        m_ptr = (m_ptr + 1) % NE;
                    end
                end else if (flush) m_keep = 0;
            end else if (pf_valid && !flush && pi < 0) begin
                m_req = 1; m_addr = pf_addr & 32'hFFFF_FFF0;
            end
            if (flush) for (int i = 0; i < NE; i++) m_v[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit e_busy, e_hit;
            int idx;
            e_busy = m_req || m_out;
            idx = find(lk_addr);
            e_hit = lk_valid && idx >= 0;
            chk("busy", busy, e_busy);
            chk("pf_ack", pf_ack, !e_busy && pf_valid && !flush);
            chk("mem_req", mem_req, m_req);
            if (m_req) chk("mem_addr", mem_addr, m_addr);
            chk("lookup_hit", lk_hit, e_hit);
            chk("lookup_data", lk_data, e_hit ? m_data[idx] : 128'h0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic fill(input logic [31:0] a, input logic [127:0] d);
        pf_valid = 1; pf_addr = a; cyc();
        pf_valid = 0; gnt = 1; cyc();
        gnt = 0; rvalid = 1; rdata = d; cyc();
        rvalid = 0;
    endtask

    task automatic probe(input string nm, input logic [31:0] a, input bit hit, input logic [127:0] d);
        lk_valid = 1; lk_addr = a; #1;
        chk({nm, "_hit"}, lk_hit, hit);
        chk({nm, "_data"}, lk_data, d);
        cyc();
        lk_valid = 0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ack"}, pf_ack, 0);
        chk({nm, "_req"}, mem_req, 0);
        chk({nm, "_addr"}, mem_addr, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_hit"}, lk_hit, 0);
        chk({nm, "_data"}, lk_data, 0);
    endtask

    initial begin
        logic [127:0] d1, d2, da, db, dc, d6;
        d1 = {4{32'hD1D1_0001}}; d2 = {4{32'hD2D2_0002}};
        da = {4{32'hAAAA_0100}}; db = {4{32'hBBBB_0110}}; dc = {4{32'hCCCC_0120}};
        d6 = {4{32'h6666_0600}};

        #12; chk_zero("reset");
        rst_n = 1;
        cyc();

        // single prefetch, immediate grant, data one cycle later
        pf_valid = 1; pf_addr = 32'h1010; #1;
        chk("t1_ack", pf_ack, 1);
        cyc(); pf_valid = 0; #1;
        chk("t1_ack_off", pf_ack, 0);
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 32'h1010);
        chk("t1_busy1", busy, 1);
        gnt = 1; cyc(); gnt = 0;
        chk("t1_busy2", busy, 1);
        chk("t1_req_off", mem_req, 0);
        rvalid = 1; rdata = d1; cyc(); rvalid = 0; #1;
        chk("t1_idle", busy, 0);
        probe("t1_lk1", 32'h101C, 1, d1);
        probe("t1_lk2", 32'h1010, 0, 0);

        // duplicate filter
        fill(32'h2000, d2);
        pf_valid = 1; pf_addr = 32'h2000; #1;
        chk("t2_ack", pf_ack, 1);
        cyc(); pf_valid = 0; #1;
        chk("t2_req", mem_req, 0);
        chk("t2_busy", busy, 0);

        // FIFO replacement
        fill(32'h100, da); fill(32'h110, db); fill(32'h120, dc);
        probe("t3_100", 32'h100, 0, 0);
        probe("t3_110", 32'h118, 1, db);
        probe("t3_120", 32'h120, 1, dc);

        // flush while waiting for data
        pf_valid = 1; pf_addr = 32'h300; cyc();
        pf_valid = 0; gnt = 1; cyc();
        gnt = 0; flush = 1; cyc();
        flush = 0; pf_valid = 1; pf_addr = 32'h400; #1;
        chk("t4_busy1", busy, 1); chk("t4_ack1", pf_ack, 0);
        cyc();
        chk("t4_busy2", busy, 1); chk("t4_ack2", pf_ack, 0);
        cyc(); rvalid = 1; rdata = {4{32'hBAD0_0300}}; #1;
        chk("t4_busy3", busy, 1); chk("t4_ack3", pf_ack, 0);
        cyc(); rvalid = 0; #1;
        chk("t4_busy4", busy, 0); chk("t4_ack4", pf_ack, 1);
        pf_valid = 0;
        probe("t4_lk", 32'h300, 0, 0);

        // flush before grant withdraws the request
        pf_valid = 1; pf_addr = 32'h500; cyc();
        pf_valid = 0; flush = 1; #1;
        chk("t5_req", mem_req, 1);
        cyc(); flush = 0; #1;
        chk("t5_req_off", mem_req, 0);
        chk("t5_busy", busy, 0);
        probe("t5_lk", 32'h500, 0, 0);

        // async reset in the middle of a read
        fill(32'h600, d6);
        pf_valid = 1; pf_addr = 32'h700; cyc();
        pf_valid = 0; gnt = 1; cyc(); gnt = 0;
        lk_valid = 1; lk_addr = 32'h604; #1;
        chk("t6_prehit", lk_hit, 1);
        chk("t6_busy", busy, 1);
        rst_n = 0; #1;
        chk_zero("t6_rst");
        cyc(); rst_n = 1; #1;
        chk("t6_post_hit", lk_hit, 0);
        lk_valid = 0;
        cyc();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            flush    = ($urandom_range(0, 19) == 0);
            pf_valid = ($urandom_range(0, 9) < 4);
            pf_addr  = 32'h8000 + 32'($urandom_range(0, 5)) * 16;
            gnt      = $urandom_range(0, 1);
            rvalid   = m_out && ($urandom_range(0, 9) < 4);
            rdata    = {$urandom, $urandom, $urandom, $urandom};
            lk_valid = ($urandom_range(0, 9) < 4);
            lk_addr  = 32'h8000 + 32'($urandom_range(0, 5)) * 16 + 32'($urandom_range(0, 15));
            cyc();
        end
        flush = 0; pf_valid = 0; gnt = 0; rvalid = 0; lk_valid = 0;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
